// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and default sizing for the stream multiplexer.
package mux_pkg;
    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting one past ptr, wrapping at N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_vld,
    output logic [SW-1:0] gnt_idx
);
    logic [SW-1:0] cand;
    // Scan farthest offset first so the nearest requester after ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = N; k >= 1; k--) begin
            cand = SW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end
endmodule

// File: rtl/muxn_stream.sv
// muxn_stream: N-channel valid/ready stream mux with explicit-select and round-robin
// modes feeding a single registered output stage.
module muxn_stream
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    localparam int SW   = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SW-1:0]           sel,
    input  logic [N-1:0][WIDTH-1:0] in_data,
    input  logic [N-1:0]            in_valid,
    output logic [N-1:0]            in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SW-1:0]           out_src
);
    localparam int NP = 2 ** SW;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    src_q, src_d, ptr_q, ptr_d;
    logic [SW-1:0]    rr_idx, gnt_idx;
    logic             rr_vld, gnt_vld, load_en, is_rr, xfer;
    logic [NP-1:0]    vld_pad;

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    // Padding lets an out-of-range sel read a zero valid instead of indexing past N.
    always_comb begin
        is_rr    = mode == MODE_RR;
        vld_pad  = NP'(in_valid);
        load_en  = !valid_q || out_ready;
        gnt_vld  = is_rr ? rr_vld : vld_pad[sel];
        gnt_idx  = is_rr ? rr_idx : sel;
        xfer     = load_en && gnt_vld;
        in_ready = (rst_n && xfer) ? N'(1) << gnt_idx : '0;
        valid_d  = load_en ? gnt_vld : valid_q;
        data_d   = xfer ? in_data[gnt_idx] : data_q;
        src_d    = xfer ? gnt_idx : src_q;
        ptr_d    = (xfer && is_rr) ? gnt_idx : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= SW'(N - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_src   = src_q;
endmodule

// File: tb/tb_muxn_stream.sv
// tb_muxn_stream: table vectors, directed corner sequences and a randomized run
// checked against a queue-free behavioural model of the stream mux.
module tb_muxn_stream;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                mode = 1'b0;
    logic [SW-1:0]       sel = '0;
    logic [N-1:0][W-1:0] in_data = '0;
    logic [N-1:0]        in_valid = '0;
    logic [N-1:0]        in_ready;
    logic [W-1:0]        out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [SW-1:0]       out_src;

    logic                mode8 = 1'b0;
    logic [2:0]          sel8 = '0;
    logic [7:0][15:0]    in_data8 = '0;
    logic [7:0]          in_valid8 = '0;
    logic [7:0]          in_ready8;
    logic [15:0]         out_data8;
    logic                out_valid8;
    logic                out_ready8 = 1'b0;
    logic [2:0]          out_src8;

    muxn_stream dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
    );

    muxn_stream #(.WIDTH(16), .N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode8), .sel(sel8), .in_data(in_data8),
        .in_valid(in_valid8), .in_ready(in_ready8), .out_data(out_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_src(out_src8)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: output register contents plus the last round-robin winner.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_src, m_ptr;

    function automatic int grant(input logic md, input int s, input logic [N-1:0] v);
        if (!md) return (s < N && v[s]) ? s : -1;
        for (int k = 1; k <= N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic mstep(input string tag);
        int g;
        logic le;
        logic [N-1:0] er;
        logic [W-1:0] d;
        #1;
        g  = grant(mode, int'(sel), in_valid);
        le = !m_valid || out_ready;
        er = (g >= 0 && le) ? N'(1 << g) : '0;
        d  = (g >= 0) ? in_data[g] : '0;
        chk({tag, "_rdy"}, in_ready, er);
        @(posedge clk);
        #1;
        if (le) begin
            m_valid = g >= 0;
            if (g >= 0) begin
                m_data = d;
                m_src  = g;
                if (mode) m_ptr = g;
            end
        end
        chk({tag, "_valid"}, out_valid, m_valid);
        chk({tag, "_data"}, out_data, m_data);
        chk({tag, "_src"}, out_src, m_src);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_src"}, out_src, 0);
        chk({tag, "_rdy"}, in_ready, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = N - 1;
    endtask

    typedef struct {
        logic       md;
        logic [1:0] s;
        logic [3:0] v;
        logic       ord;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] src;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[1] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[2] = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[3] = '{1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[4] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[5] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[6] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd1};
        tbl[7] = '{1'b1, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[8] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[9] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        #1;
        chk("init_valid", out_valid, 0);
        chk("init_data", out_data, 0);
        chk("init_src", out_src, 0);
        chk("init_rdy", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) in_data[i] = 32'hA000_0000 + i;
        for (int i = 0; i < 10; i++) begin
            mode = tbl[i].md; sel = tbl[i].s; in_valid = tbl[i].v; out_ready = tbl[i].ord;
            #1;
            chk($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_src", i), out_src, tbl[i].src);
            chk($sformatf("tbl%0d_data", i), out_data, 32'hA000_0000 + tbl[i].src);
        end

        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data[2] = 32'hDEADBEEF; out_ready = 1'b1;
        #1;
        chk("sel2_rdy", in_ready, 4'b0100);
        @(posedge clk);
        #1;
        chk("sel2_valid", out_valid, 1);
        chk("sel2_data", out_data, 32'hDEADBEEF);
        chk("sel2_src", out_src, 2);

        do_reset("rst1");
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_valid", i), out_valid, 1);
            chk($sformatf("rr%0d_src", i), out_src, i % 4);
        end

        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data[0] = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("stall_load", out_data, 32'h1234_5678);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode = 1'($urandom); sel = 2'($urandom); in_valid = 4'($urandom) | 4'b0001;
            for (int c = 0; c < N; c++) in_data[c] = $urandom;
            #1;
            chk($sformatf("stall%0d_rdy", i), in_ready, 0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", i), out_valid, 1);
            chk($sformatf("stall%0d_data", i), out_data, 32'h1234_5678);
            chk($sformatf("stall%0d_src", i), out_src, 0);
        end

        do_reset("midrst");
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        mstep("post_rst");
        chk("post_rst_ch0", out_src, 0);

        do_reset("rst2");
        for (int i = 0; i < 400; i++) begin
            mode = 1'($urandom); sel = 2'($urandom); in_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) in_data[c] = $urandom;
            mstep($sformatf("rnd%0d", i));
        end

        for (int c = 0; c < 8; c++) in_data8[c] = 16'h1000 + 16'(c);
        in_data8[7] = 16'hBEEF;
        mode8 = 1'b0; sel8 = 3'd7; in_valid8 = 8'h80; out_ready8 = 1'b1;
        #1;
        chk("n8_rdy", in_ready8, 8'h80);
        @(posedge clk);
        #1;
        chk("n8_valid", out_valid8, 1);
        chk("n8_src", out_src8, 7);
        chk("n8_data", out_data8, 16'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
